// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared sizing helper and rounding-mode constants for the sqrt pipeline
package sqrt_pkg;

  localparam int SQRT_TRUNC = 0;
  localparam int SQRT_ROUND = 1;

  // Result width: half the integer bits (rounded up) plus the requested fraction bits.
  function automatic int sqrt_out_width(input int in_w, input int in_dec_w, input int out_dec_w);
    return (in_w - in_dec_w + 1) / 2 + out_dec_w;
  endfunction

endpackage

// File: rtl/sqrt_stage.sv
// rtl/sqrt_stage.sv - one registered non-restoring square-root step resolving a single root bit
module sqrt_stage #(
  parameter int OW     = 12,
  parameter int RW     = 24,
  parameter int REM_W  = 16,
  parameter int CHAN_W = 2,
  parameter int STAGE  = 0
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              ce,
  input  logic              i_valid,
  input  logic [CHAN_W-1:0] i_chan,
  input  logic [OW-1:0]     i_root,
  input  logic [REM_W-1:0]  i_rem,
  input  logic [RW-1:0]     i_rad,
  output logic              o_valid,
  output logic [CHAN_W-1:0] o_chan,
  output logic [OW-1:0]     o_root,
  output logic [REM_W-1:0]  o_rem,
  output logic [RW-1:0]     o_rad
);

  localparam bit LAST = (STAGE == OW - 1);

  logic              r_valid;
  logic [CHAN_W-1:0] r_chan;
  logic [OW-1:0]     r_root;
  logic [REM_W-1:0]  r_rem;
  logic [RW-1:0]     r_rad;

  logic              w_neg;
  logic [REM_W-1:0]  w_shifted;
  logic [REM_W-1:0]  w_root_term;
  logic [REM_W-1:0]  w_step_rem;
  logic [REM_W-1:0]  w_corr_term;
  logic [REM_W-1:0]  w_next_rem;
  logic [OW-1:0]     w_next_root;

  // Remainder is two's complement; its MSB selects subtract (root<<2|01) or add (root<<2|11).
  assign w_neg       = i_rem[REM_W-1];
  assign w_shifted   = (i_rem << 2) | {{(REM_W-2){1'b0}}, i_rad[RW-1 -: 2]};
  assign w_root_term = {{(REM_W-OW-2){1'b0}}, i_root, w_neg, 1'b1};
  assign w_step_rem  = w_neg ? (w_shifted + w_root_term) : (w_shifted - w_root_term);
  assign w_next_root = {i_root[OW-2:0], ~w_step_rem[REM_W-1]};

  // The last step folds the negative-remainder fix-up in combinationally, so no extra cycle.
  assign w_corr_term = {{(REM_W-OW-1){1'b0}}, w_next_root, 1'b1};
  assign w_next_rem  = (LAST && w_step_rem[REM_W-1]) ? (w_step_rem + w_corr_term) : w_step_rem;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_rad   <= '0;
    end else if (ce) begin
      r_valid <= i_valid;
      r_chan  <= i_chan;
      r_root  <= w_next_root;
      r_rem   <= w_next_rem;
      r_rad   <= i_rad << 2;
    end
  end

  assign o_valid = r_valid;
  assign o_chan  = r_chan;
  assign o_root  = r_root;
  assign o_rem   = r_rem;
  assign o_rad   = r_rad;

endmodule

// File: rtl/sqrt_fixedpoint_pipe.sv
// rtl/sqrt_fixedpoint_pipe.sv - fully pipelined unsigned fixed-point square root with tag and clock enable
module sqrt_fixedpoint_pipe
  import sqrt_pkg::*;
#(
  parameter int inputWidth     = 16,
  parameter int inputDecWidth  = 8,
  parameter int outputDecWidth = 8,
  parameter int ROUND          = SQRT_TRUNC,
  parameter int CHAN_W         = 2
) (
  input  logic                                                              clk,
  input  logic                                                              aclr,
  input  logic                                                              ce,
  input  logic                                                              in_valid,
  input  logic [inputWidth-1:0]                                             radical,
  input  logic [CHAN_W-1:0]                                                 in_chan,
  output logic                                                              out_valid,
  output logic [sqrt_out_width(inputWidth, inputDecWidth, outputDecWidth)-1:0] q,
  output logic [sqrt_out_width(inputWidth, inputDecWidth, outputDecWidth):0]   remainder,
  output logic [CHAN_W-1:0]                                                 out_chan
);

  localparam int intW        = inputWidth - inputDecWidth;
  localparam int outputWidth = (intW + 1) / 2 + outputDecWidth;
  localparam int RW          = 2 * outputWidth;
  localparam int REM_W       = outputWidth + 4;
  localparam int QRW         = outputWidth + 1;
  localparam int SHIFT       = 2 * outputDecWidth - inputDecWidth;

  if (2 * outputDecWidth < inputDecWidth) begin : g_bad_precision
    $error("sqrt_fixedpoint_pipe: outputDecWidth must be at least half of inputDecWidth");
  end

  logic              w_valid [0:outputWidth];
  logic [CHAN_W-1:0] w_chan  [0:outputWidth];
  logic [outputWidth-1:0] w_root [0:outputWidth];
  logic [REM_W-1:0]  w_rem   [0:outputWidth];
  logic [RW-1:0]     w_rad   [0:outputWidth];

  assign w_valid[0] = in_valid;
  assign w_chan[0]  = in_chan;
  assign w_root[0]  = '0;
  assign w_rem[0]   = '0;
  assign w_rad[0]   = RW'(radical) << SHIFT;

  for (genvar k = 0; k < outputWidth; k++) begin : g_stage
    sqrt_stage #(
      .OW     (outputWidth),
      .RW     (RW),
      .REM_W  (REM_W),
      .CHAN_W (CHAN_W),
      .STAGE  (k)
    ) u_stage (
      .clk     (clk),
      .aclr    (aclr),
      .ce      (ce),
      .i_valid (w_valid[k]),
      .i_chan  (w_chan[k]),
      .i_root  (w_root[k]),
      .i_rem   (w_rem[k]),
      .i_rad   (w_rad[k]),
      .o_valid (w_valid[k+1]),
      .o_chan  (w_chan[k+1]),
      .o_root  (w_root[k+1]),
      .o_rem   (w_rem[k+1]),
      .o_rad   (w_rad[k+1])
    );
  end

  logic [outputWidth-1:0] w_qfloor;
  logic [QRW-1:0]         w_rem_floor;
  logic                   w_unused;

  // After correction the remainder is non-negative and at most 2*qfloor, so QRW bits hold it.
  assign w_qfloor    = w_root[outputWidth];
  assign w_rem_floor = w_rem[outputWidth][QRW-1:0];
  assign w_unused    = ^{w_rad[outputWidth], w_rem[outputWidth][REM_W-1:QRW]};

  if (ROUND == SQRT_ROUND) begin : g_round
    logic                   r_valid;
    logic [CHAN_W-1:0]      r_chan;
    logic [outputWidth-1:0] r_q;
    logic [QRW-1:0]         r_rem;
    logic                   w_round_up;

    // rem > qfloor is exactly sqrt(R) >= qfloor + 0.5; an all-ones root saturates instead.
    assign w_round_up = (w_rem_floor > {1'b0, w_qfloor}) && !(&w_qfloor);

    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        r_valid <= 1'b0;
        r_chan  <= '0;
        r_q     <= '0;
        r_rem   <= '0;
      end else if (ce) begin
        r_valid <= w_valid[outputWidth];
        r_chan  <= w_chan[outputWidth];
        r_q     <= w_qfloor + {{(outputWidth-1){1'b0}}, w_round_up};
        r_rem   <= w_rem_floor;
      end
    end

    assign out_valid = r_valid;
    assign out_chan  = r_chan;
    assign q         = r_q;
    assign remainder = r_rem;
  end else begin : g_trunc
    assign out_valid = w_valid[outputWidth];
    assign out_chan  = w_chan[outputWidth];
    assign q         = w_qfloor;
    assign remainder = w_rem_floor;
  end

endmodule

// File: doc/sqrt_fixedpoint_pipe.md
Name: sqrt_fixedPoint_pipe

Overview:
- Parametrised, fully pipelined unsigned fixed-point square root built in plain RTL (non-restoring, one result bit per stage). It is the successor to the vendor-IP sqrt wrapper.
- Adds valid/tag handshake, a global clock-enable stall, selectable output fractional precision and optional round-to-nearest with saturation.
- Sits in the DSP path after magnitude/power computation. Accepts one sample per cycle; the channel tag travels with each sample.

Parameters:
- inputWidth, 16, radical width (unsigned).
- inputDecWidth, 8, fractional bits of radical.
- outputDecWidth, 8, fractional bits of q. Must satisfy 2*outputDecWidth >= inputDecWidth (elaboration error otherwise).
- ROUND, 0, 0 = truncate (floor), 1 = round-to-nearest with saturation.
- CHAN_W, 2, width of the sideband tag.
- Derived (localparam): intW = inputWidth-inputDecWidth; outputWidth = (intW+1)/2 + outputDecWidth; RW = 2*outputWidth; LAT = outputWidth + ROUND.

Ports:
- clk  in  1  clock
- aclr  in  1  asynchronous, active-high reset
- ce  in  1  pipeline enable; 0 freezes every register
- in_valid  in  1  radical/in_chan qualifier
- radical  in  inputWidth  unsigned fixed-point operand
- in_chan  in  CHAN_W  tag, carried unchanged
- out_valid  out  1  q/remainder/out_chan qualifier
- q  out  outputWidth  sqrt, outputDecWidth fractional bits
- remainder  out  outputWidth+1  R - qfloor^2 (pre-rounding)
- out_chan  out  CHAN_W  tag of the result

Behaviour:
- Radicand: R = zero-extend(radical << (2*outputDecWidth-inputDecWidth)) to RW bits.
- Floor result: qfloor = floor(sqrt(R)), exact integer. remainder = R - qfloor^2, always in 0..2*qfloor.
- Stage k (k = 0..outputWidth-1) resolves result bit outputWidth-1-k. Each stage registers the partial root, the signed partial remainder and the remaining radicand bits.
- Non-restoring recurrence: subtract (root<<2|01) when remainder >= 0, add (root<<2|11) otherwise. A final correction adds (root<<1|1) when the last remainder is negative; this correction is combinational in the last stage, with no extra cycle.
- ROUND=1 adds one registered stage: q = qfloor + (remainder > qfloor). If qfloor is all ones, q saturates at all ones. remainder still reports the floor remainder.
- Latency: exactly LAT ce-enabled cycles from the in_valid sample to out_valid. Throughput is 1 per enabled cycle, with no bubbles required.
- in_valid=0 samples propagate as bubbles. Data registers may hold don't-care values, but out_valid=0.
- ce=0: all pipeline registers, including valid and tag, hold. Outputs are stable. Input is not sampled.
- Reset: every register clears asynchronously on aclr=1, giving out_valid=0, q=0, remainder=0, out_chan=0. Reset mid-pipeline discards all in-flight samples. The first valid after release emerges LAT enabled cycles later.
- No state machine beyond the valid shift chain. No backpressure; downstream must accept every out_valid.

Decomposition:
- Shared package sqrt_pkg holds:
  - a function computing outputWidth from (inputWidth, inputDecWidth, outputDecWidth), reused by instantiating parents to size wires;
  - the ROUND mode constants (SQRT_TRUNC=0, SQRT_ROUND=1).
- One sub-module, sqrt_stage, is natural: one registered non-restoring step, parametrised by stage index, with ce and aclr. It is instantiated outputWidth times in a generate loop.

Test Plan (default params, outputWidth=12, LAT=12 at ROUND=0, 13 at ROUND=1):
- radical 0x0400 (4.0) -> q=0x200 (2.0), remainder=0, out_valid exactly 12 cycles later; ROUND=1 gives the same q at cycle 13.
- radical 0x0200 (2.0) -> q=0x16A, remainder=28; ROUND=1 -> q=0x16A (28 <= 362).
- radical 0xFFFF -> q=0xFFF, remainder=7935; ROUND=1 -> 7935 > 4095, saturates to q=0xFFF. Also radical 0x0000 -> q=0, remainder=0, and 0x0001 -> q=0x010.
- Back-to-back valids every cycle with tags 0,1,2,3 and random radicals, ce toggled pseudo-randomly -> results in order against a reference model. Tags match, no duplicates or drops, outputs frozen while ce=0.
- aclr asserted for 1 cycle with 6 samples in flight -> out_valid=0 immediately (asynchronous) and those samples never emerge. A sample applied after release appears LAT cycles later.
- Sweep over all 65536 radicals, both ROUND values -> q^2 <= R < (q+1)^2 (truncate). For rounding, |q - sqrt(R)| <= 0.5 LSB except at saturation.
